// File: rtl/lcd_bus.sv
// lcd_bus: queued command/data/pixel writer driving an 8080-style 8-bit panel bus.
// Define LCD_RGB565_EN to add 2-byte RGB565 pixel packing selected by the fmt control bit.
module lcd_bus #(
    parameter int WR_LOW     = 2,
    parameter int WR_HIGH    = 2,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  sel,
    input  logic        go,
    input  logic [17:0] a,
    output logic        busy,
    output logic        idle,
    output logic [7:0]  lcd_d,
    output logic        lcd_wrx,
    output logic        lcd_dcx,
    output logic        lcd_csx,
    output logic        lcd_resx
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
`ifdef LCD_RGB565_EN
    localparam int EW    = 21;
`else
    localparam int EW    = 20;
`endif

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [EW-1:0]         r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  r_busy;
    logic                  r_cs_hold;
    logic                  r_resx;
    logic                  r_dcx;
    logic [3:0]            r_tmr;
    logic [1:0]            r_left;
    logic [1:0]            w_nleft;
    logic [15:0]           r_shift;
    logic [15:0]           w_rest;
    logic [7:0]            r_d;
    logic [7:0]            w_b0;
    logic                  w_push;
    logic                  w_ctrl;
    logic                  w_pop;
    logic                  w_next;
    logic                  w_phase_end;
    logic                  w_empty;
    logic [EW-1:0]         w_entry;
    logic [EW-1:0]         w_head;
    logic [1:0]            w_kind;
    logic [17:0]           w_px;
    logic                  w_efmt;
    logic                  w_p18;

`ifdef LCD_RGB565_EN
    logic                  r_fmt;
    logic                  w_p565;
    assign w_entry = {sel, r_fmt, a};
    assign w_efmt  = w_head[18];
    assign w_p565  = (w_kind == 2'd2) && w_efmt;
`else
    assign w_entry = {sel, a};
    assign w_efmt  = 1'b0;
`endif

    assign w_push    = go && (sel != 2'd3) && !r_busy;
    assign w_ctrl    = go && (sel == 2'd3);
    assign w_empty   = (r_cnt == '0);
    assign w_head    = r_mem[r_rp];
    assign w_kind    = w_head[EW-1 -: 2];
    assign w_px      = w_head[17:0];
    assign w_p18     = (w_kind == 2'd2) && !w_efmt;
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= w_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt == CW'(DEPTH));
        end
    end

    // Control writes bypass the FIFO and never touch the serializer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_hold <= 1'b0;
            r_resx    <= 1'b0;
`ifdef LCD_RGB565_EN
            r_fmt     <= 1'b0;
`endif
        end else if (w_ctrl) begin
            r_cs_hold <= a[1];
            r_resx    <= a[2];
`ifdef LCD_RGB565_EN
            r_fmt     <= a[0];
`endif
        end
    end

    always_comb begin
        w_b0    = w_px[7:0];
        w_rest  = '0;
        w_nleft = 2'd0;
        unique case (1'b1)
            w_p18: begin
                w_b0    = {w_px[17:12], 2'b00};
                w_rest  = {w_px[11:6], 2'b00, w_px[5:0], 2'b00};
                w_nleft = 2'd2;
            end
`ifdef LCD_RGB565_EN
            w_p565: begin
                w_b0    = {w_px[17:13], w_px[11:9]};
                w_rest  = {w_px[8:6], w_px[5:1], 8'h00};
                w_nleft = 2'd1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_next      = 1'b0;
        w_phase_end = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = LOW;
                end
            end
            LOW: begin
                if (r_tmr == 4'(WR_LOW - 1)) begin
                    w_phase_end = 1'b1;
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (r_tmr == 4'(WR_HIGH - 1)) begin
                    w_phase_end = 1'b1;
                    if (r_left != 2'd0) begin
                        w_next      = 1'b1;
                        w_state_nxt = LOW;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = LOW;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop || w_phase_end) r_tmr <= '0;
            else if (r_state != IDLE) r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d     <= 8'h00;
            r_dcx   <= 1'b1;
            r_shift <= '0;
            r_left  <= 2'd0;
        end else if (w_pop) begin
            r_d     <= w_b0;
            r_dcx   <= (w_kind != 2'd0);
            r_shift <= w_rest;
            r_left  <= w_nleft;
        end else if (w_next) begin
            r_d     <= r_shift[15:8];
            r_shift <= {r_shift[7:0], 8'h00};
            r_left  <= r_left - 2'd1;
        end
    end

    assign busy     = r_busy;
    assign idle     = w_empty && (r_state == IDLE);
    assign lcd_d    = r_d;
    assign lcd_wrx  = (r_state != LOW);
    assign lcd_dcx  = r_dcx;
    assign lcd_csx  = !((r_state != IDLE) || r_cs_hold);
    assign lcd_resx = r_resx;
endmodule

// File: doc/lcd_bus.md
# lcd_bus

Downstream stage of the GPU: accepts command bytes, data bytes and 18-bit pixels on the CPU's sel/go/a port style, buffers them in a small FIFO, and drives an 8-bit 8080-style write-only bus to an ILI9341/ILI9488 panel. Pixels are serialized as 3 bytes (18bpp) or, when compiled in, 2 bytes (RGB565). WRX strobe widths are set by parameters.

## Interface
- WR_LOW, 2: cycles WRX is held low per byte, 1..15.
- WR_HIGH, 2: cycles WRX is held high per byte, 1..15.
- DEPTH_LOG2, 2: log2 of FIFO entries; the default gives 4 entries.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  2  0=command byte, 1=data byte, 2=pixel, 3=control.
- go  in  1  one-cycle request qualified by sel.
- a  in  18  payload: byte in a[7:0] for sel 0/1; pixel {R6,G6,B6} for sel 2; control bits for sel 3.
- busy  out  1  FIFO full.
- idle  out  1  FIFO empty and serializer idle.
- lcd_d  out  8  bus data.
- lcd_wrx  out  1  write strobe; the panel latches on the rising edge.
- lcd_dcx  out  1  0=command, 1=data.
- lcd_csx  out  1  chip select, active low.
- lcd_resx  out  1  panel reset, active low.

## Operation
- Entry format: {kind[1:0], fmt, data[17:0]}.
- Push: go & sel!=3 & !busy writes one entry, capturing the current fmt.
- go while busy is dropped. It has no side effects and is not retried.
- Control (go & sel==3) applies immediately and is never queued:
  - a[0] = fmt: 0=18bpp, 1=565.
  - a[1] = cs_hold.
  - a[2] = resx level.
- A control write never disturbs queued entries or the byte in flight.
- FSM states: IDLE, LOW, HIGH.
- IDLE → LOW: taken when the FIFO is non-empty.
  - Pops the head entry and loads the byte shifter.
  - Loads the byte count: 1 for command/data, 3 for 18bpp pixel, 2 for 565 pixel.
- LOW: lcd_wrx=0 for WR_LOW cycles, then go to HIGH.
- HIGH: lcd_wrx=1 for WR_HIGH cycles, then:
  - more bytes in the entry: next byte, go to LOW;
  - entry done, FIFO non-empty: pop, go to LOW (back-to-back, no IDLE cycle);
  - entry done, FIFO empty: go to IDLE.
- 18bpp byte order: {R6,00}, {G6,00}, {B6,00}, with R6=a[17:12], G6=a[11:6], B6=a[5:0].
- 565 byte order: {a[17:13], a[11:9]}, then {a[8:6], a[5:1]}. The LSB of R and of B is dropped.
- lcd_dcx = 0 for command entries and 1 otherwise. It changes only when an entry is loaded and is held through that entry's last HIGH phase.
- lcd_d changes only on entry into LOW.
- lcd_csx = 0 whenever state != IDLE or cs_hold = 1.
- A simultaneous push and pop on a non-empty FIFO is legal; the count is unchanged.

## Timing
- Reset values:
  - lcd_wrx=1, lcd_csx=1, lcd_dcx=1, lcd_d=0.
  - lcd_resx=0: the panel stays in reset until software writes a[2]=1.
  - busy=0, idle=1, fmt=0, cs_hold=0.
- Latency, push into an empty idle block at cycle N:
  - entry is visible at N+1 and popped at N+1;
  - lcd_wrx is low from N+2;
  - idle falls at N+1.
- Per-byte period is WR_LOW+WR_HIGH cycles. Defaults:
  - 4 cycles per byte;
  - 12 cycles per 18bpp pixel;
  - 8 cycles per 565 pixel.
- busy is registered and reflects the count after this cycle's push/pop. busy rises the cycle after the push that fills the FIFO.
- Reset mid-byte (asynchronous):
  - all outputs take their reset values immediately;
  - the FIFO is emptied;
  - the partial byte is lost.

## Configuration
- LCD_RGB565_EN defined: fmt is honoured and 565 entries emit 2 bytes.
- LCD_RGB565_EN not defined:
  - fmt is tied to 0 and a[0] of the control write is ignored;
  - the fmt field and the 565 packing logic are removed;
  - pixels always emit 3 bytes.

## Test plan
- Reset, then control a=3'b100 → lcd_resx=1, lcd_csx=1, idle=1, no WRX edges.
- Command 0x2C then pixel 0x3F03F (18bpp), defaults →
  - 0x2C with dcx=0, then 0xFC, 0x00, 0xFC with dcx=1;
  - 4 WRX rising edges, no IDLE gap;
  - csx low throughout.
- With LCD_RGB565_EN, fmt=1, pixel 0x3FFC0 → bytes 0xFF, 0xE0. Then fmt=0 with a pixel already queued → that pixel still emits 2 bytes.
- Push 6 data bytes on consecutive cycles from idle →
  - busy rises after the FIFO fills;
  - the go that arrives while busy is dropped;
  - exactly 5 bytes appear on lcd_d, in order.
- cs_hold=1, one data byte → csx stays low after return to IDLE. Then cs_hold=0 → csx rises the next cycle.
- Assert rst_n during the second byte of a pixel →
  - wrx=1, csx=1, resx=0 immediately;
  - idle=1 after release;
  - no further WRX edges.
